// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync pulses and pipeline-aligned blank/strobes for pixel renderers
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        blank_d,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY > 7 || PIPE_DELAY < 0) begin : g_param_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and PIPE_DELAY in 0..7");
    end

    logic                        run;
    logic                        h_end;
    logic                        v_end;
    logic [9:0]                  nx;
    logic [9:0]                  ny;
    logic [2:0]                  stage;
    logic [PIPE_DELAY:0][2:0]    sync_pipe;

    // next raster position (held at origin on the start-up edge) and its {hs, vs, blank} levels
    always_comb begin
        h_end = DrawX == 10'(H_TOTAL - 1);
        v_end = DrawY == 10'(V_TOTAL - 1);
        nx    = (!run || h_end) ? 10'd0 : DrawX + 10'd1;
        ny    = !run ? 10'd0 : h_end ? (v_end ? 10'd0 : DrawY + 10'd1) : DrawY;
        stage = {(nx >= 10'(HS_FIRST) && nx <= 10'(HS_LAST)) ? SYNC_POL : ~SYNC_POL,
                 (ny >= 10'(VS_FIRST) && ny <= 10'(VS_LAST)) ? SYNC_POL : ~SYNC_POL,
                 nx < 10'(H_VISIBLE) && ny < 10'(V_VISIBLE)};
    end

    // raster counters, zero-skew blank, strobes and frame counter
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            run         <= 1'b1;
            DrawX       <= nx;
            DrawY       <= ny;
            blank       <= stage[0];
            line_start  <= nx == 10'd0;
            frame_start <= nx == 10'd0 && ny == 10'd0;
            if (run && h_end && v_end) frame_count <= frame_count + 16'd1;
        end
    end

    // stage 0 is co-timed with DrawX; the last stage lines up with the renderers' RGB pipeline
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_pipe <= {(PIPE_DELAY + 1){IDLE}};
        end else begin
            sync_pipe[0] <= stage;
            for (int i = 1; i <= PIPE_DELAY; i++) sync_pipe[i] <= sync_pipe[i - 1];
        end
    end

    assign {hs, vs, blank_d} = sync_pipe[PIPE_DELAY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for default, reduced-size and positive-sync/no-delay instances
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  d_x, d_y, s_x, s_y, p_x, p_y;
    logic        d_b, d_bd, d_hs, d_vs, d_ls, d_fs;
    logic        s_b, s_bd, s_hs, s_vs, s_ls, s_fs;
    logic        p_b, p_bd, p_hs, p_vs, p_ls, p_fs;
    logic [15:0] d_fc, s_fc, p_fc;
    logic [41:0] vd, vs_, vp;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_b), .blank_d(d_bd),
        .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_sml (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_b), .blank_d(s_bd),
        .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

    vga_timing_gen #(.SYNC_POL(1'b1), .PIPE_DELAY(0)) u_pol (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(p_x), .DrawY(p_y), .blank(p_b), .blank_d(p_bd),
        .hs(p_hs), .vs(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc));

    assign vd  = {d_x, d_y, d_b, d_bd, d_hs, d_vs, d_ls, d_fs, d_fc};
    assign vs_ = {s_x, s_y, s_b, s_bd, s_hs, s_vs, s_ls, s_fs, s_fc};
    assign vp  = {p_x, p_y, p_b, p_bd, p_hs, p_vs, p_ls, p_fs, p_fc};

    typedef struct {
        int          t;
        logic [41:0] d;
        logic [41:0] s;
        logic [41:0] p;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t = 0;
    bit   run_tb = 1'b0;
    logic prev_dhs, prev_svs;
    int   hs_fall, vs_fall;
    logic [9:0] x1, x2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected outputs t edges after the start-up edge, derived from absolute raster position
    function automatic logic [41:0] model(input int tc, input int hv, input int hf, input int hsw, input int hb,
                                          input int vv, input int vf, input int vsw, input int vb,
                                          input bit pol, input int d);
        int ht, vt, ft, x, y, fc, p, xp, yp;
        logic ha, va, bd;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        ft = ht * vt;
        x  = (tc % ft) % ht;
        y  = (tc % ft) / ht;
        fc = (tc / ft) % 65536;
        ha = 1'b0;
        va = 1'b0;
        bd = 1'b0;
        if (tc >= d) begin
            p  = (tc - d) % ft;
            xp = p % ht;
            yp = p / ht;
            ha = xp >= hv + hf && xp < hv + hf + hsw;
            va = yp >= vv + vf && yp < vv + vf + vsw;
            bd = xp < hv && yp < vv;
        end
        return {10'(x), 10'(y), x < hv && y < vv, bd, ha ? pol : ~pol, va ? pol : ~pol,
                x == 0, x == 0 && y == 0, 16'(fc)};
    endfunction

    function automatic logic [41:0] rst_vec(input bit pol);
        return {20'd0, 1'b0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 16'd0};
    endfunction

    // push the expected result of every edge while the DUTs run
    always @(posedge clk) begin
        if (run_tb) begin
            q.push_back('{t, model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2),
                             model(t, 8, 2, 3, 3, 6, 1, 2, 1, 1'b0, 2),
                             model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 0)});
            t++;
        end
    end

    // pop and compare mid-cycle, plus pulse-shape measurements
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("def", 64'(vd), 64'(e.d));
            check("sml", 64'(vs_), 64'(e.s));
            check("pol", 64'(vp), 64'(e.p));
            if (e.t == 0)
                check("first_edge", 64'(vd), 64'({10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0}));
            if (e.t == 640) check("x640_blank", 64'({d_x, d_b}), 64'({10'd640, 1'b0}));
            if (e.t == 656) check("pol_hs_rise", 64'({p_x, p_hs}), 64'({10'd656, 1'b1}));
            if (e.t == 752) check("pol_hs_fall", 64'({p_x, p_hs}), 64'({10'd752, 1'b0}));
            if (e.t == 160) check("sml_wrap", 64'({s_x, s_y, s_fs, s_fc}), 64'({10'd0, 10'd0, 1'b1, 16'd1}));
            if (prev_dhs && !d_hs) begin
                check("hs_fall_lag", 64'(x2), 64'd656);
                if (hs_fall >= 0) check("hs_period", 64'(e.t - hs_fall), 64'd800);
                hs_fall = e.t;
            end
            if (!prev_dhs && d_hs && hs_fall >= 0) check("hs_low_len", 64'(e.t - hs_fall), 64'd96);
            if (prev_svs && !s_vs) vs_fall = e.t;
            if (!prev_svs && s_vs && vs_fall >= 0) check("vs_low_len", 64'(e.t - vs_fall), 64'd32);
            prev_dhs = d_hs;
            prev_svs = s_vs;
            x2 = x1;
            x1 = d_x;
        end
    end

    task automatic restart();
        prev_dhs = 1'b1;
        prev_svs = 1'b1;
        hs_fall  = -1;
        vs_fall  = -1;
        x1 = '0;
        x2 = '0;
        t = 0;
        reset_n = 1'b1;
        run_tb = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_def", 64'(vd), 64'(rst_vec(1'b0)));
        check("rst_sml", 64'(vs_), 64'(rst_vec(1'b0)));
        check("rst_pol", 64'(vp), 64'(rst_vec(1'b1)));
        restart();
        repeat (1700) @(negedge clk);
        #1;
        reset_n = 1'b0;
        run_tb = 1'b0;
        #2;
        check("midrst_def", 64'(vd), 64'(rst_vec(1'b0)));
        check("midrst_sml", 64'(vs_), 64'(rst_vec(1'b0)));
        check("midrst_pol", 64'(vp), 64'(rst_vec(1'b1)));
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_sml", 64'(vs_), 64'(rst_vec(1'b0)));
        restart();
        repeat (900) @(negedge clk);
        #1;
        check("sb_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
